maxpool2x2_seq: RTL

- Sequential 2x2, stride-2 max-pooling stage directly downstream of the ReLU activation stage.
- Accepts one flattened feature map per handshake and computes one pooled output element per clock.
- Presents the complete pooled map, held stable, on a valid/ready output handshake for the next layer (next conv stage or flatten/FC).

---
 rtl/maxpool2x2_seq.sv | 118 +++++++++++
 1 files changed

// File: rtl/maxpool2x2_seq.sv
// rtl/maxpool2x2_seq.sv - sequential 2x2 stride-2 signed max-pool stage, one pooled element per clock
module maxpool2x2_seq #(
  parameter int fm_width   = 5,
  parameter int fm_height  = 5,
  parameter int value_size = 16
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [fm_width*fm_height*value_size-1:0]   In_map,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [(fm_width/2)*(fm_height/2)*value_size-1:0] Out_map,
  output logic                                       busy
);

  localparam int out_w     = fm_width / 2;
  localparam int out_h     = fm_height / 2;
  localparam int n_out     = out_w * out_h;
  localparam int n_in      = fm_width * fm_height;
  localparam int total_in  = n_in * value_size;
  localparam int total_out = n_out * value_size;
  localparam int idx_w     = (n_out > 1) ? $clog2(n_out) : 1;
  localparam int ew        = (n_in > 1) ? $clog2(n_in) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                      state, state_d;
  logic [total_in-1:0]         map_q;
  logic [total_out-1:0]        res_q;
  logic [total_out-1:0]        res_d;
  logic [idx_w-1:0]            idx;
  logic                        last;
  logic signed [value_size-1:0] elem [n_in];
  logic signed [value_size-1:0] e0, e1, e2, e3, m_top, m_bot, max_val;
  int                          orow, ocol, base;

  // Element 0 sits at the MSB end of the captured map.
  for (genvar i = 0; i < n_in; i++) begin : g_elem
    assign elem[i] = map_q[total_in-1-i*value_size -: value_size];
  end

  // One shared 4-input comparator tree; idx selects the window.
  always_comb begin
    orow = int'(idx) / out_w;
    ocol = int'(idx) % out_w;
    base = 2 * orow * fm_width + 2 * ocol;
    e0 = elem[ew'(base)];
    e1 = elem[ew'(base + 1)];
    e2 = elem[ew'(base + fm_width)];
    e3 = elem[ew'(base + fm_width + 1)];
    m_top   = (e0 > e1) ? e0 : e1;
    m_bot   = (e2 > e3) ? e2 : e3;
    max_val = (m_top > m_bot) ? m_top : m_bot;
  end

  always_comb begin
    res_d = res_q;
    for (int k = 0; k < n_out; k++) begin
      if (int'(idx) == k) res_d[total_out-1-k*value_size -: value_size] = max_val;
    end
    last = (int'(idx) == n_out - 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      map_q   <= '0;
      res_q   <= '0;
      idx     <= '0;
      Out_map <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            map_q <= In_map;
            idx   <= '0;
          end
        end
        RUN: begin
          res_q <= res_d;
          idx   <= last ? '0 : idx + 1'b1;
          // Publish the whole buffer, including the element computed this edge.
          if (last) Out_map <= res_d;
        end
        default: ;
      endcase
    end
  end

endmodule
